// File: rtl/pulse_measure.sv
// Trigger-armed pulse timer: timestamps the first rising and following falling
// edge of sig_in relative to trig and reports rise/fall/width with a valid strobe.
module pulse_measure #(
    parameter int          WIDTH       = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             trig,
    input  logic             sig_in,
    output logic [WIDTH-1:0] t_rise,
    output logic [WIDTH-1:0] t_fall,
    output logic [WIDTH-1:0] t_width,
    output logic             valid,
    output logic             timeout,
    output logic             busy,
    output logic             restart
);

    localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ARM, RISE, FALL, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] rise_int, rise_int_d;
    logic             restart_d;
    logic             s;

    logic             load;
    logic             tmo_c;
    logic [WIDTH-1:0] rise_o, fall_o, width_o;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = sig_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= sig_in;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++)
                        sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        rise_int_d = rise_int;
        restart_d  = restart;
        load       = 1'b0;
        tmo_c      = 1'b0;
        rise_o     = '1;
        fall_o     = '1;
        width_o    = '0;
        busy       = 1'b0;

        case (state)
            IDLE: begin
                if (trig) begin
                    cnt_d   = WIDTH'(1);
                    state_d = s ? ARM : RISE;
                end
            end
            ARM, RISE, FALL: begin
                busy = 1'b1;
                // Retrigger takes priority over both edge capture and timeout
                if (trig) begin
                    cnt_d     = WIDTH'(1);
                    state_d   = s ? ARM : RISE;
                    restart_d = 1'b1;
                end else if (cnt == TMO) begin
                    state_d = DONE;
                    load    = 1'b1;
                    tmo_c   = 1'b1;
                    if (state == FALL) rise_o = rise_int;
                end else begin
                    cnt_d = cnt + WIDTH'(1);
                    if (state == ARM && !s) begin
                        state_d = RISE;
                    end else if (state == RISE && s) begin
                        rise_int_d = cnt;
                        state_d    = FALL;
                    end else if (state == FALL && !s) begin
                        state_d = DONE;
                        load    = 1'b1;
                        rise_o  = rise_int;
                        fall_o  = cnt;
                        width_o = cnt - rise_int;
                    end
                end
            end
            DONE: begin
                if (trig) begin
                    cnt_d   = WIDTH'(1);
                    state_d = s ? ARM : RISE;
                end else begin
                    restart_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Results are loaded on the edge into DONE, so valid is high during DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            rise_int <= '0;
            restart  <= 1'b0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            t_rise   <= '0;
            t_fall   <= '0;
            t_width  <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            rise_int <= rise_int_d;
            restart  <= restart_d;
            valid    <= load;
            timeout  <= load & tmo_c;
            if (load) begin
                t_rise  <= rise_o;
                t_fall  <= fall_o;
                t_width <= width_o;
            end
        end
    end

endmodule

// File: tb/tb_pulse_measure.sv
// Scoreboard bench for pulse_measure: directed vectors push expected results,
// per-DUT monitors pop and compare on every valid strobe.
module tb_pulse_measure;

    logic clk = 1'b0;
    logic rstn;
    logic trig0, trig2, sig_in;

    logic [15:0] r0, f0, w0, r2, f2, w2;
    logic        v0, to0, b0, rs0, v2, to2, b2, rs2;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [15:0] r, f, w;
        logic        tmo, rst;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    pulse_measure #(.WIDTH(16), .SYNC_STAGES(0), .TIMEOUT(20)) dut0 (
        .clk(clk), .rstn(rstn), .trig(trig0), .sig_in(sig_in),
        .t_rise(r0), .t_fall(f0), .t_width(w0),
        .valid(v0), .timeout(to0), .busy(b0), .restart(rs0)
    );

    pulse_measure #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(20)) dut2 (
        .clk(clk), .rstn(rstn), .trig(trig2), .sig_in(sig_in),
        .t_rise(r2), .t_fall(f2), .t_width(w2),
        .valid(v2), .timeout(to2), .busy(b2), .restart(rs2)
    );

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] bits(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic exp_t mk(input logic [15:0] r, input logic [15:0] f,
                                input logic [15:0] w, input logic tmo, input logic rst);
        exp_t e;
        e.r = r; e.f = f; e.w = w; e.tmo = tmo; e.rst = rst;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (v0) begin
            if (q0.size() == 0) begin
                checks++; fails++;
                $display("FAIL dut0 unexpected valid: got 1 expected 0 at %0t", $time);
            end else begin
                e = q0.pop_front();
                cmp("dut0 t_rise", r0, e.r);
                cmp("dut0 t_fall", f0, e.f);
                cmp("dut0 t_width", w0, e.w);
                cmp("dut0 timeout", 16'(to0), 16'(e.tmo));
                cmp("dut0 restart", 16'(rs0), 16'(e.rst));
            end
        end
        if (v2) begin
            if (q2.size() == 0) begin
                checks++; fails++;
                $display("FAIL dut2 unexpected valid: got 1 expected 0 at %0t", $time);
            end else begin
                e = q2.pop_front();
                cmp("dut2 t_rise", r2, e.r);
                cmp("dut2 t_fall", f2, e.f);
                cmp("dut2 t_width", w2, e.w);
                cmp("dut2 timeout", 16'(to2), 16'(e.tmo));
                cmp("dut2 restart", 16'(rs2), 16'(e.rst));
            end
        end
    end

    // Cycle c starts 1 time unit after the c-th clock edge seen by this task
    task automatic drive(input int from, input int to, input logic [63:0] sp,
                         input logic [63:0] tp, input bit sel2);
        for (int c = from; c < to; c++) begin
            @(posedge clk);
            #1;
            sig_in = sp[c];
            trig0  = sel2 ? 1'b0 : tp[c];
            trig2  = sel2 ? tp[c] : 1'b0;
        end
    endtask

    task automatic expect_drained(input string name);
        cmp({name, " pending results"}, 16'(q0.size() + q2.size()), 16'd0);
        q0.delete();
        q2.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; trig0 = 1'b0; trig2 = 1'b0; sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset t_rise", r0, 16'd0);
        cmp("reset t_fall", f0, 16'd0);
        cmp("reset t_width", w0, 16'd0);
        cmp("reset flags", 16'({v0, to0, b0, rs0}), 16'd0);
        cmp("reset dut2 flags", 16'({v2, to2, b2, rs2}), 16'd0);
        rstn = 1'b1;

        q0.push_back(mk(16'd5, 16'd10, 16'd5, 1'b0, 1'b0));
        drive(0, 20, bits(5, 9), bits(0, 0), 1'b0);
        expect_drained("basic sync0");

        q2.push_back(mk(16'd7, 16'd12, 16'd5, 1'b0, 1'b0));
        drive(0, 20, bits(5, 9), bits(0, 0), 1'b1);
        expect_drained("basic sync2");

        q0.push_back(mk(16'd8, 16'd11, 16'd3, 1'b0, 1'b0));
        drive(0, 20, bits(0, 2) | bits(8, 10), bits(0, 0), 1'b0);
        expect_drained("arm path");

        q0.push_back(mk(16'hFFFF, 16'hFFFF, 16'd0, 1'b1, 1'b0));
        drive(0, 30, 64'd0, bits(0, 0), 1'b0);
        expect_drained("timeout no rise");

        q0.push_back(mk(16'd4, 16'hFFFF, 16'd0, 1'b1, 1'b0));
        drive(0, 30, bits(4, 25), bits(0, 0), 1'b0);
        expect_drained("timeout no fall");

        q0.push_back(mk(16'd3, 16'd6, 16'd3, 1'b0, 1'b1));
        drive(0, 6, bits(6, 8), bits(0, 0) | bits(3, 3), 1'b0);
        cmp("restart before valid", 16'(rs0), 16'd1);
        cmp("busy mid measurement", 16'(b0), 16'd1);
        drive(6, 14, bits(6, 8), bits(0, 0) | bits(3, 3), 1'b0);
        cmp("restart after valid", 16'(rs0), 16'd0);
        expect_drained("retrigger");

        drive(0, 9, bits(2, 20), bits(0, 0), 1'b0);
        cmp("busy in FALL", 16'(b0), 16'd1);
        #3;
        rstn = 1'b0;
        #1;
        cmp("async reset t_rise", r0, 16'd0);
        cmp("async reset t_fall", f0, 16'd0);
        cmp("async reset t_width", w0, 16'd0);
        cmp("async reset flags", 16'({v0, to0, b0, rs0}), 16'd0);
        sig_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        q0.push_back(mk(16'd2, 16'd5, 16'd3, 1'b0, 1'b0));
        drive(0, 12, bits(2, 4), bits(0, 0), 1'b0);
        expect_drained("after reset");
        cmp("t_rise held", r0, 16'd2);
        cmp("t_width held", w0, 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
